// File: rtl/sha256_msg_sched_if.sv
// Big-endian message word stream between the AXI-side buffer and the SHA-256 scheduler.
interface sha256_msg_sched_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [1:0]  s_bytes;
  logic        s_ready;

  modport master (output s_data, s_valid, s_last, s_bytes, input s_ready);
  modport slave  (input s_data, s_valid, s_last, s_bytes, output s_ready);
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 padder/scheduler: pads the word stream into 512-bit blocks, drives the
// round core with its 68-cycle-per-block timing and registers the final digest.
module sha256_msg_sched (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  sha256_msg_sched_if.slave   msg,
  output logic                core_init,
  output logic                core_en,
  output logic [31:0]         core_idata,
  input  logic [255:0]        core_hash,
  output logic [255:0]        digest,
  output logic                digest_valid,
  output logic                busy
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_DATA, S_COMP, S_DONE} state_t;
  typedef enum logic [1:0] {PH_MSG, PH_PAD80, PH_ZERO} phase_t;

  state_t      state;
  phase_t      phase;
  logic [6:0]  cnt;
  logic [31:0] byte_cnt;
  logic        len_ok;
  logic        final_blk;

  logic [31:0] tail_word;
  logic [31:0] last_add;
  logic [31:0] zero_word;

  // The 0x80 marker lands right after the last valid byte of a short final word.
  always_comb begin
    case (msg.s_bytes)
      2'd1:    tail_word = {msg.s_data[31:24], 8'h80, 16'h0000};
      2'd2:    tail_word = {msg.s_data[31:16], 8'h80, 8'h00};
      2'd3:    tail_word = {msg.s_data[31:8], 8'h80};
      default: tail_word = msg.s_data;
    endcase
    last_add = (msg.s_bytes == 2'd0) ? 32'd4 : {30'd0, msg.s_bytes};

    zero_word = 32'd0;
    if (len_ok && cnt == 7'd14)
      zero_word = {29'd0, byte_cnt[31:29]};
    else if (len_ok && cnt == 7'd15)
      zero_word = {byte_cnt[28:0], 3'b000};

    msg.s_ready = (state == S_DATA) && (phase == PH_MSG);
    core_init   = (state == S_INIT);
    core_en     = 1'b0;
    core_idata  = 32'd0;
    if (state == S_DATA) begin
      case (phase)
        PH_MSG: begin
          core_en    = msg.s_valid;
          core_idata = msg.s_last ? tail_word : msg.s_data;
        end
        PH_PAD80: begin
          core_en    = 1'b1;
          core_idata = 32'h8000_0000;
        end
        default: begin
          core_en    = 1'b1;
          core_idata = zero_word;
        end
      endcase
    end else if (state == S_COMP) begin
      core_en = 1'b1;
    end
  end

  // cnt tracks the core's own round counter, so it only moves on core_en cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      phase        <= PH_MSG;
      cnt          <= 7'd0;
      byte_cnt     <= 32'd0;
      len_ok       <= 1'b0;
      final_blk    <= 1'b0;
      digest       <= 256'd0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_INIT;
            phase     <= PH_MSG;
            byte_cnt  <= 32'd0;
            len_ok    <= 1'b0;
            final_blk <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_INIT: begin
          state <= S_DATA;
          cnt   <= 7'd0;
        end
        S_DATA: begin
          if (core_en) begin
            cnt <= cnt + 7'd1;
            if (cnt == 7'd15)
              state <= S_COMP;
            case (phase)
              PH_MSG: begin
                if (msg.s_last) begin
                  byte_cnt <= byte_cnt + last_add;
                  if (msg.s_bytes == 2'd0) begin
                    phase <= PH_PAD80;
                  end else begin
                    phase <= PH_ZERO;
                    if (cnt <= 7'd13)
                      len_ok <= 1'b1;
                  end
                end else begin
                  byte_cnt <= byte_cnt + 32'd4;
                end
              end
              PH_PAD80: begin
                phase <= PH_ZERO;
                if (cnt <= 7'd13)
                  len_ok <= 1'b1;
              end
              default: begin
                if (len_ok && cnt == 7'd15)
                  final_blk <= 1'b1;
              end
            endcase
          end
        end
        S_COMP: begin
          if (cnt == 7'd67) begin
            cnt <= 7'd0;
            if (final_blk) begin
              state <= S_DONE;
            end else begin
              state <= S_DATA;
              // A block that starts with nothing but zero fill always has room for the length.
              if (phase == PH_ZERO)
                len_ok <= 1'b1;
            end
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        S_DONE: begin
          digest       <= core_hash;
          digest_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
          cnt          <= 7'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: a behavioural round core plus a padding/digest
// scoreboard built from an independent software SHA-256 model.
module tb_sha256_msg_sched;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_56  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    logic [255:0] dig;
    int           lat;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         core_init;
  logic         core_en;
  logic [31:0]  core_idata;
  logic [255:0] core_hash;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  sha256_msg_sched_if msg_if();

  sha256_msg_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .msg          (msg_if),
    .core_init    (core_init),
    .core_en      (core_en),
    .core_idata   (core_idata),
    .core_hash    (core_hash),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           en_gaps = 0;
  int           extra_words = 0;
  int           extra_dv = 0;
  int           ready_timeouts = 0;
  int           core_r;
  logic [511:0] core_blk;
  logic [255:0] last_digest;
  logic [7:0]   msg_bytes[$];
  logic [31:0]  pad_words[$];
  logic [31:0]  exp_words[$];
  logic [31:0]  issued_q[$];
  sb_t          sb_q[$];

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[32*(15-i) +: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  task automatic buildPadded();
    logic [7:0]  pb[$];
    logic [63:0] bits;
    pb = msg_bytes;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    bits = 64'(msg_bytes.size()) << 3;
    for (int i = 7; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
    pad_words.delete();
    for (int i = 0; i < pb.size(); i += 4)
      pad_words.push_back({pb[i], pb[i+1], pb[i+2], pb[i+3]});
  endtask

  function automatic logic [255:0] swDigest();
    logic [255:0] h;
    logic [511:0] blk;
    h = IV;
    for (int b = 0; b < pad_words.size() / 16; b++) begin
      for (int i = 0; i < 16; i++) blk[32*(15-i) +: 32] = pad_words[16*b + i];
      h = compress(h, blk);
    end
    return h;
  endfunction

  // Behavioural round core: collects words 0..15, compresses on its 68th EN cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_r    <= 0;
      core_hash <= '0;
    end else if (core_init) begin
      core_r    <= 0;
      core_hash <= IV;
    end else if (core_en) begin
      if (core_r < 16) begin
        core_blk[32*(15-core_r) +: 32] <= core_idata;
        issued_q.push_back(core_idata);
      end
      if (core_r == 67) begin
        core_hash <= compress(core_hash, core_blk);
        core_r    <= 0;
      end else begin
        core_r <= core_r + 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sb_t         e;
    logic [31:0] ew;
    if (rst_n) begin
      if (core_en && core_r < 16) begin
        if (exp_words.size() > 0) begin
          ew = exp_words.pop_front();
          checkOutput($sformatf("idata_cnt%0d", core_r), 256'(core_idata), 256'(ew));
        end else begin
          extra_words++;
        end
      end
      if (core_r >= 16 && !core_en) en_gaps++;
      if (digest_valid) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checkOutput("digest", digest, e.dig);
          checkOutput("latency", 256'(cyc - start_cyc), 256'(e.lat));
        end else begin
          extra_dv++;
        end
      end
    end
  end

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int guard;
    guard = 0;
    msg_if.s_data  = d;
    msg_if.s_valid = 1'b1;
    msg_if.s_last  = last;
    msg_if.s_bytes = nb;
    while (!msg_if.s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) ready_timeouts++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [255:0] known, input int stall, input bit expect_done,
                               input logic [7:0] fill);
    sb_t         e;
    int          n, nw, guard, low;
    logic [31:0] w;
    n = msg_bytes.size();
    buildPadded();
    foreach (pad_words[i]) exp_words.push_back(pad_words[i]);
    e.dig = (known != '0) ? known : swDigest();
    e.lat = 70 + 68 * (pad_words.size() / 16 - 1) + stall;
    if (expect_done) sb_q.push_back(e);
    issued_q.delete();
    pulseStart();
    if (stall > 0) begin
      guard = 0;
      while (!msg_if.s_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      low = 0;
      for (int i = 0; i < stall; i++) begin
        if (!core_en) low++;
        @(negedge clk);
      end
      checkOutput("stall_en_low", 256'(low), 256'(stall));
    end
    nw = (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      for (int b = 0; b < 4; b++) w = {w[23:0], (4*i + b < n) ? msg_bytes[4*i + b] : fill};
      sendWord(w, i == nw - 1, 2'(n % 4));
    end
    msg_if.s_valid = 1'b0;
    msg_if.s_last  = 1'b0;
    if (expect_done) begin
      guard = 0;
      while (sb_q.size() > 0 && guard < 600) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("sb_drained", 256'(sb_q.size()), 256'(0));
      sb_q.delete();
      last_digest = e.dig;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic loadString(input string s);
    msg_bytes.delete();
    for (int i = 0; i < s.len(); i++) msg_bytes.push_back(s[i]);
  endtask

  task automatic loadRandom(input int n);
    msg_bytes.delete();
    for (int i = 0; i < n; i++) msg_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    msg_if.s_data  = 32'd0;
    msg_if.s_valid = 1'b0;
    msg_if.s_last  = 1'b0;
    msg_if.s_bytes = 2'd0;
    #3;
    checkOutput("rst_ctrl", 256'({msg_if.s_ready, core_init, core_en, digest_valid, busy}), 256'(0));
    checkOutput("rst_idata", 256'(core_idata), 256'(0));
    checkOutput("rst_digest", digest, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] abc");
    loadString("abc");
    applyStimulus(DIG_ABC, 0, 1'b1, 8'h00);
    checkOutput("abc_w0", 256'(issued_q[0]), 256'(32'h61626380));
    checkOutput("abc_w15", 256'(issued_q[15]), 256'(32'h00000018));

    $display("[TB] 56-byte two-block message");
    loadString("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    applyStimulus(DIG_56, 0, 1'b1, 8'h00);

    $display("[TB] abc with 5-cycle stall");
    loadString("abc");
    applyStimulus(DIG_ABC, 5, 1'b1, 8'h00);

    $display("[TB] 64-byte message");
    loadRandom(64);
    applyStimulus('0, 0, 1'b1, 8'hA5);
    checkOutput("b2_pad80", 256'(issued_q[16]), 256'(32'h80000000));
    checkOutput("b2_len", 256'(issued_q[31]), 256'(32'h00000200));

    $display("[TB] random 55, 61, 70 byte messages");
    loadRandom(55);
    applyStimulus('0, 0, 1'b1, 8'hA5);
    loadRandom(61);
    applyStimulus('0, 0, 1'b1, 8'h5A);
    loadRandom(70);
    applyStimulus('0, 0, 1'b1, 8'hC3);

    $display("[TB] start ignored in COMP, then reset mid-COMP");
    loadString("abc");
    applyStimulus('0, 0, 1'b0, 8'h00);
    repeat (10) @(negedge clk);
    checkOutput("digest_hold", digest, last_digest);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_ign_init", 256'(core_init), 256'(0));
    checkOutput("start_ign_busy", 256'(busy), 256'(1));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ctrl", 256'({msg_if.s_ready, core_init, core_en, digest_valid, busy}), 256'(0));
    checkOutput("midrst_idata", 256'(core_idata), 256'(0));
    checkOutput("midrst_digest", digest, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_words.delete();
    sb_q.delete();

    $display("[TB] abc after reset");
    loadString("abc");
    applyStimulus(DIG_ABC, 0, 1'b1, 8'h00);

    checkOutput("en_gaps", 256'(en_gaps), 256'(0));
    checkOutput("extra_words", 256'(extra_words + exp_words.size()), 256'(0));
    checkOutput("extra_dv", 256'(extra_dv), 256'(0));
    checkOutput("ready_timeouts", 256'(ready_timeouts), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Message scheduler and padder for the SHA-256 round core. It accepts a big-endian 32-bit word stream, applies standard SHA-256 padding (the 0x80 byte, zero fill and the 64-bit bit length), and splits the message into 512-bit blocks. It drives the core's `init`/`EN`/`idata` controls with the core's 68-round-per-block timing, then registers the 256-bit digest. It sits between the AXI-side message buffer and the SHA-256 core.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a new message. Ignored while `busy`.
- `s_data`  in  32  message word; byte 0 is in `[31:24]`.
- `s_valid`  in  1  `s_data` is valid.
- `s_last`  in  1  marks the final message word.
- `s_bytes`  in  2  valid bytes in the last word: 1..3, with 0 meaning 4. Ignored unless `s_last`.
- `s_ready`  out  1  scheduler accepts a word this cycle.
- `core_init`  out  1  to core `init`.
- `core_en`  out  1  to core `EN`.
- `core_idata`  out  32  to core `idata`.
- `core_hash`  in  256  `{Hash0..Hash7}` from the core.
- `digest`  out  256  registered final hash.
- `digest_valid`  out  1  one-cycle pulse when `digest` updates.
- `busy`  out  1  high from the cycle after `start` is accepted until `digest_valid`.

## Operation
- **States:** IDLE, INIT, DATA (`cnt` 0..15), COMP (`cnt` 16..67), DONE.
  - `cnt` is 7 bits and mirrors the core's round counter.
- **IDLE → INIT** on `start`.
  - Clears the byte counter (32 bits), `phase` := MSG, and `len_ok`, `final` := 0.
- **INIT:** `core_init` = 1 for exactly one cycle, `core_en` = 0, then go to DATA with `cnt` = 0.
- **DATA:** each `core_en` cycle, `core_idata` carries word `cnt`, then `cnt` increments. At `cnt` 15 the next state is COMP.
- **Word source by `phase`:**
  - MSG:
    - `s_ready` = 1, `core_en` = `s_valid`, `core_idata` = `s_data`.
    - Each transfer adds 4 to the byte count, or `s_bytes` on the last word.
  - Last word with 1..3 bytes:
    - Valid bytes are kept, the next byte is 0x80, lower bytes are 0.
    - `phase` := ZERO.
  - Last word with 4 bytes: `phase` := PAD80.
  - PAD80: word 0x80000000, `phase` := ZERO.
  - `len_ok` := 1 when the 0x80-bearing word is issued at `cnt` ≤ 13.
  - ZERO:
    - `cnt` < 14: word 0.
    - `cnt` 14/15 with `len_ok`: words `{29'b0, bytes[31:29]}` then `{bytes[28:0], 3'b0}`; set `final`.
    - Otherwise: word 0.
  - In any non-MSG phase, `core_en` = 1 and `s_ready` = 0.
- **COMP:**
  - `core_en` = 1 continuously for `cnt` 16..67.
  - At `cnt` 67: go to DONE if `final`, else to DATA with `cnt` = 0.
  - Entering a new block in phase ZERO sets `len_ok` := 1.
- **DONE:** `digest` <= `core_hash`, `digest_valid` <= 1, go to IDLE. No `init` is issued between blocks of one message.
- **Core `EN` constraint:**
  - `core_en` may drop only in DATA/MSG stalls.
  - It must never be low at `cnt` 16..67, because the core's Hash registers update on the round value regardless of `EN`.
- **Boundaries:**
  - Message bytes mod 64 ≤ 55 finishes in one final block; otherwise an extra block is added.
  - A last full word at `cnt` 15 puts PAD80 at `cnt` 0 of the next block.
  - Minimum message length is 1 byte; maximum is 2^32−1 bytes.
- **Ignored inputs:**
  - `s_valid` outside DATA/MSG is ignored.
  - `start` in any state other than IDLE is ignored.
  - `start` together with a DONE cycle is ignored.

## Timing
- **Reset values:**
  - `s_ready`, `core_init`, `core_en`, `digest_valid`, `busy` = 0.
  - `core_idata` = 0, `digest` = 0.
  - State IDLE, `cnt` = 0.
  - `rst_n` mid-message returns to IDLE at once. The core shares `rst_n`, so no cleanup is required.
- **Latency** is measured from the edge that samples `start`, with no stalls:
  - INIT: 1 cycle.
  - Per block: 68 `core_en` cycles.
  - DONE: 1 cycle.
  - `digest_valid` is high after edge 70 for one block, and after edge 70 + 68·(n−1) for n blocks.
- Each DATA cycle with `s_valid` = 0 in MSG adds one cycle.
- `s_ready` is combinational from state/phase only, with no dependency on `s_valid`.
- `digest` holds until the next DONE.

## Test plan
- **"abc":**
  - Stimulus: `start`, then one word 0x61626300 with `s_last`, `s_bytes` = 3.
  - Required: `digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; `digest_valid` after edge 70; `core_idata` at `cnt` 15 = 0x00000018.
- **56-byte "abcdbcdecdef…nopq":**
  - Required: two blocks; `digest` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; `digest_valid` after edge 138.
- **Stall:** "abc" with `s_valid` held low for 5 DATA cycles.
  - Required: same digest at edge 75; `core_en` = 0 exactly during the stall; `core_en` never 0 at `cnt` 16..67.
- **64-byte message:** last word full at `cnt` 15.
  - Required: PAD80 issues 0x80000000 at `cnt` 0 of block 2; length word 0x00000200 at block-2 `cnt` 15; digest matches the software model.
- **Reset:** `start` pulsed during COMP is ignored, then `rst_n` is asserted mid-COMP.
  - Required: all outputs go to 0 and the state to IDLE; a following "abc" run gives the correct digest.
